// File: rtl/router_pkt_fifo.sv
// rtl/router_pkt_fifo.sv - parametrised router output-channel packet FIFO with header tagging
//
// Optional feature macro: ROUTER_PKT_FIFO_ERR_EN (sticky overflow/underflow flags).
//
// Ports:
//   clock          single clock, all logic on posedge
//   reset          synchronous active-high reset (clears everything incl. tags and error flags)
//   soft_reset     synchronous flush (pointers, packet counter, output); error flags kept
//   write_enb      write request; data_in stored with tag = lfd_state of previous cycle
//   lfd_state      load-first-data: word written next cycle is a header
//   data_in        write data
//   read_enb       read request
//   data_out       registered read data (data bits only)
//   rd_valid       data_out holds a word popped at the last edge
//   full/empty     occupancy extremes
//   almost_full    level >= AFULL_THRESH
//   level          words stored
//   pkt_busy       read side is mid-packet (remaining count non-zero)
//   overflow_err   sticky: write attempted while full (0 unless ERR_EN)
//   underflow_err  sticky: read attempted while empty (0 unless ERR_EN)
module router_pkt_fifo #(
    parameter int DATA_WIDTH   = 8,
    parameter int DEPTH        = 16,
    parameter int LEN_LSB      = 2,
    parameter int LEN_WIDTH    = 6,
    parameter int AFULL_THRESH = DEPTH - 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    soft_reset,
    input  logic                    write_enb,
    input  logic                    lfd_state,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    read_enb,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    rd_valid,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    pkt_busy,
    output logic                    overflow_err,
    output logic                    underflow_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int RW = LEN_WIDTH + 1;
    localparam logic [PW-1:0] AFULL_L = PW'(AFULL_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]      tag_q;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [RW-1:0]         rem_q;
    logic                  lfd_q;

    logic                  wr_fire;
    logic                  rd_fire;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  rd_tag;

    // Extra MSB on the pointers distinguishes full from empty when the
    // index bits match.
    assign empty       = (wr_ptr == rd_ptr);
    assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level       = wr_ptr - rd_ptr;
    assign almost_full = (level >= AFULL_L);
    assign pkt_busy    = (rem_q != '0);

    // Flushes win over same-cycle traffic; full/empty use pre-edge pointers.
    assign wr_fire = write_enb && !full && !soft_reset && !reset;
    assign rd_fire = read_enb && !empty && !soft_reset && !reset;

    assign rd_word = mem[rd_ptr[AW-1:0]];
    assign rd_tag  = tag_q[rd_ptr[AW-1:0]];

    always_ff @(posedge clock) begin
        if (wr_fire) begin
            mem[wr_ptr[AW-1:0]] <= data_in;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tag_q <= '0;
        end else if (wr_fire) begin
            tag_q[wr_ptr[AW-1:0]] <= lfd_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || soft_reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rem_q    <= '0;
            lfd_q    <= 1'b0;
            data_out <= '0;
            rd_valid <= 1'b0;
        end else begin
            lfd_q <= lfd_state;
            if (wr_fire) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_fire) begin
                rd_ptr   <= rd_ptr + PW'(1);
                data_out <= rd_word;
                rd_valid <= 1'b1;
                // Header length covers the payload; +1 accounts for the parity word.
                if (rd_tag) begin
                    rem_q <= {1'b0, rd_word[LEN_LSB +: LEN_WIDTH]} + RW'(1);
                end else if (rem_q != '0) begin
                    rem_q <= rem_q - RW'(1);
                end
            end else begin
                rd_valid <= 1'b0;
                // Idle between packets: do not leave stale data on the port.
                if (rem_q == '0) begin
                    data_out <= '0;
                end
            end
        end
    end

`ifdef ROUTER_PKT_FIFO_ERR_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else if (!soft_reset) begin
            if (write_enb && full) begin
                overflow_err <= 1'b1;
            end
            if (read_enb && empty) begin
                underflow_err <= 1'b1;
            end
        end
    end
`else
    assign overflow_err  = 1'b0;
    assign underflow_err = 1'b0;
`endif

endmodule

// File: tb/tb_router_pkt_fifo.sv
// tb/tb_router_pkt_fifo.sv - directed self-checking bench for router_pkt_fifo
module tb_router_pkt_fifo;

`ifdef ROUTER_PKT_FIFO_ERR_EN
    localparam logic ERR = 1'b1;
`else
    localparam logic ERR = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       soft_reset;
    logic       write_enb;
    logic       lfd_state;
    logic [7:0] data_in;
    logic       read_enb;
    logic [7:0] data_out;
    logic       rd_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic [4:0] level;
    logic       pkt_busy;
    logic       overflow_err;
    logic       underflow_err;

    int n_checks = 0;
    int n_errors = 0;

    router_pkt_fifo dut (
        .clock        (clock),
        .reset        (reset),
        .soft_reset   (soft_reset),
        .write_enb    (write_enb),
        .lfd_state    (lfd_state),
        .data_in      (data_in),
        .read_enb     (read_enb),
        .data_out     (data_out),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .level        (level),
        .pkt_busy     (pkt_busy),
        .overflow_err (overflow_err),
        .underflow_err(underflow_err)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        write_enb  = 1'b0;
        read_enb   = 1'b0;
        lfd_state  = 1'b0;
        soft_reset = 1'b0;
        reset      = 1'b0;
    endtask

    task automatic put(input logic [7:0] d);
        write_enb = 1'b1;
        data_in   = d;
        step();
        write_enb = 1'b0;
    endtask

    initial begin
        logic [7:0] pkt [5];
        pkt[0] = 8'h0C; pkt[1] = 8'h11; pkt[2] = 8'h22; pkt[3] = 8'h33; pkt[4] = 8'h2A;

        idle();
        data_in = 8'h00;
        reset   = 1'b1;
        step();
        step();
        reset = 1'b0;
        check_val("rst_empty", 32'(empty), 1);
        check_val("rst_level", 32'(level), 0);
        check_val("rst_dout", 32'(data_out), 0);
        check_val("rst_rdv", 32'(rd_valid), 0);
        check_val("rst_full", 32'(full), 0);
        check_val("rst_afull", 32'(almost_full), 0);
        check_val("rst_busy", 32'(pkt_busy), 0);
        check_val("rst_ovf", 32'(overflow_err), 0);
        check_val("rst_udf", 32'(underflow_err), 0);

        // Header 0x0C -> length 3; remaining goes 4,3,2,1,0 over the five pops.
        lfd_state = 1'b1;
        step();
        lfd_state = 1'b0;
        for (int i = 0; i < 5; i++) put(pkt[i]);
        check_val("pkt_level", 32'(level), 5);
        read_enb = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check_val($sformatf("pkt_dout%0d", i), 32'(data_out), 32'(pkt[i]));
            check_val($sformatf("pkt_rdv%0d", i), 32'(rd_valid), 1);
            check_val($sformatf("pkt_busy%0d", i), 32'(pkt_busy), (i < 4) ? 1 : 0);
        end
        read_enb = 1'b0;
        step();
        check_val("pkt_dout_clr", 32'(data_out), 0);
        check_val("pkt_rdv_idle", 32'(rd_valid), 0);
        check_val("pkt_empty", 32'(empty), 1);

        // Fill 16 (pointers start at 5 so the drain wraps).
        for (int i = 0; i < 16; i++) begin
            put(8'h40 + 8'(i));
            if (i == 12) check_val("afull_13", 32'(almost_full), 0);
            if (i == 13) check_val("afull_14", 32'(almost_full), 1);
        end
        check_val("fill_full", 32'(full), 1);
        check_val("fill_level", 32'(level), 16);
        put(8'hEE);
        check_val("ovf_level", 32'(level), 16);
        check_val("ovf_flag", 32'(overflow_err), 32'(ERR));
        read_enb = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            check_val($sformatf("drain%0d", i), 32'(data_out), 32'(8'h40 + 8'(i)));
        end
        read_enb = 1'b0;
        step();
        check_val("drain_empty", 32'(empty), 1);

        // Level 5, then simultaneous read+write for 10 cycles.
        for (int i = 0; i < 5; i++) put(8'h80 + 8'(i));
        check_val("rw_level0", 32'(level), 5);
        read_enb  = 1'b1;
        write_enb = 1'b1;
        for (int k = 0; k < 10; k++) begin
            data_in = 8'h85 + 8'(k);
            step();
            check_val($sformatf("rw_dout%0d", k), 32'(data_out), 32'(8'h80 + 8'(k)));
            check_val($sformatf("rw_level%0d", k), 32'(level), 5);
        end
        read_enb  = 1'b0;
        write_enb = 1'b0;
        for (int i = 0; i < 11; i++) put(8'h8F + 8'(i));
        check_val("rwf_full", 32'(full), 1);
        read_enb  = 1'b1;
        write_enb = 1'b1;
        data_in   = 8'hFF;
        step();
        read_enb  = 1'b0;
        write_enb = 1'b0;
        check_val("rwf_dout", 32'(data_out), 32'h8A);
        check_val("rwf_level", 32'(level), 15);

        // Mid-packet soft reset at remaining=2, level=4.
        soft_reset = 1'b1;
        step();
        soft_reset = 1'b0;
        lfd_state = 1'b1;
        step();
        lfd_state = 1'b0;
        for (int i = 0; i < 5; i++) put(pkt[i]);
        put(8'h55);
        put(8'h66);
        read_enb = 1'b1;
        step();
        step();
        step();
        read_enb = 1'b0;
        check_val("sr_pre_level", 32'(level), 4);
        check_val("sr_pre_busy", 32'(pkt_busy), 1);
        soft_reset = 1'b1;
        step();
        soft_reset = 1'b0;
        check_val("sr_empty", 32'(empty), 1);
        check_val("sr_level", 32'(level), 0);
        check_val("sr_busy", 32'(pkt_busy), 0);
        check_val("sr_dout", 32'(data_out), 0);
        check_val("sr_ovf_kept", 32'(overflow_err), 32'(ERR));

        // New packet after flush: header 0x04 -> length 1, remaining 2.
        lfd_state = 1'b1;
        step();
        lfd_state = 1'b0;
        put(8'h04);
        put(8'h77);
        put(8'h73);
        read_enb = 1'b1;
        step();
        check_val("np_hdr", 32'(data_out), 32'h04);
        check_val("np_busy0", 32'(pkt_busy), 1);
        step();
        check_val("np_pay", 32'(data_out), 32'h77);
        check_val("np_busy1", 32'(pkt_busy), 1);
        step();
        check_val("np_par", 32'(data_out), 32'h73);
        check_val("np_busy2", 32'(pkt_busy), 0);

        // Read while empty.
        step();
        read_enb = 1'b0;
        check_val("udf_rdv", 32'(rd_valid), 0);
        check_val("udf_empty", 32'(empty), 1);
        check_val("udf_level", 32'(level), 0);
        check_val("udf_flag", 32'(underflow_err), 32'(ERR));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/router_pkt_fifo.md
# router_pkt_fifo

Parametrised packet FIFO for the router output channels, replacing the fixed 8-bit × 16 channel FIFO. It stores a header tag alongside each word and tracks the remaining bytes of the packet being read. It also provides occupancy/almost-full status, a real flush on soft reset, and a registered read-valid instead of tri-stated idle data. One instance sits between the router's write-side FSM/synchroniser and each output port.

## Interface
- DATA_WIDTH, 8: word width; ≥ LEN_LSB+LEN_WIDTH.
- DEPTH, 16: word entries; power of 2, ≥ 4.
- LEN_LSB, 2: LSB of payload-length field in a header word.
- LEN_WIDTH, 6: width of payload-length field.
- AFULL_THRESH, DEPTH-2: level at or above which almost_full asserts.

- clock  in  1  single clock, all logic posedge.
- reset  in  1  synchronous, active-high.
- soft_reset  in  1  synchronous flush (read-timeout abort).
- write_enb  in  1  write request.
- lfd_state  in  1  load-first-data; the word written next cycle is a header.
- data_in  in  DATA_WIDTH  write data.
- read_enb  in  1  read request.
- data_out  out  DATA_WIDTH  registered read data.
- rd_valid  out  1  data_out holds a word popped last cycle.
- full  out  1  DEPTH words stored.
- empty  out  1  no words stored.
- almost_full  out  1  level ≥ AFULL_THRESH.
- level  out  $clog2(DEPTH)+1  words stored.
- pkt_busy  out  1  read side is mid-packet (remaining count ≠ 0).
- overflow_err  out  1  sticky: write attempted while full.
- underflow_err  out  1  sticky: read attempted while empty.

## Operation
- Storage: DEPTH × (DATA_WIDTH+1); bit DATA_WIDTH is the header tag.
- Pointers: $clog2(DEPTH)+1 bits, wrap naturally. empty = (wr_ptr == rd_ptr). full = MSBs differ and lower bits equal. level = wr_ptr − rd_ptr (modulo).
- lfd_q is lfd_state registered. A write stores tag = lfd_q.
- Write: write_enb && !full stores {lfd_q, data_in} at wr_ptr and increments wr_ptr. Write while full is dropped and leaves memory and pointers unchanged.
- Read: read_enb && !empty loads data_out from the rd_ptr word (data bits only), sets rd_valid=1 and increments rd_ptr. Otherwise rd_valid=0 and data_out holds its value. When remaining reaches 0 with no read, data_out clears to 0.
- Remaining counter (LEN_WIDTH+1 bits):
  - On a read of a tagged word, load field[LEN_LSB+:LEN_WIDTH] + 1, covering payload and parity.
  - On a read of an untagged word with remaining ≠ 0, decrement.
  - The counter never underflows.
  - pkt_busy = (remaining ≠ 0).
- Simultaneous read+write: both proceed in the same cycle. full/empty are evaluated on pre-edge pointers, so write-when-full is rejected even if a read also occurs, and read-when-empty is rejected even if a write also occurs. level is unchanged.
- soft_reset: rd_ptr=wr_ptr=0, remaining=0, lfd_q=0, data_out=0, rd_valid=0. Stored contents become don't-care. Error flags are kept.
- reset (priority over soft_reset): same as soft_reset, plus error flags cleared and all tags cleared.

## Timing
- Reset values: data_out=0, rd_valid=0, full=0, empty=1, almost_full=0, level=0, pkt_busy=0, overflow_err=0, underflow_err=0.
- Read latency: 1 cycle (read_enb at edge N → data_out/rd_valid valid after edge N).
- full, empty, almost_full, level and pkt_busy are combinational from registers, so they update the cycle after the causing edge.
- Write-to-read: a word written at edge N can be popped at edge N+1.
- Header tagging: lfd_state must be high in the cycle before the header write.
- soft_reset, reset: take effect at the next edge. A read or write in the same cycle is ignored.

## Configuration
- ROUTER_PKT_FIFO_ERR_EN:
  - Defined: overflow_err sets on write_enb && full; underflow_err sets on read_enb && empty. Both are sticky until reset.
  - Undefined: both ports are tied 0 and no flag logic is built.

## Test plan
- reset for 2 cycles → empty=1, level=0, data_out=0, rd_valid=0, all flags 0.
- lfd_state pulse, then write header 8'h0C (len 3) and 3 payload words plus parity; read 5 words → pkt_busy goes 1 after the header pop, decrements 4,3,2,1,0; rd_valid high each pop; data_out=0 the cycle after the last pop.
- DEPTH=16: write 16 words → full=1, level=16, almost_full=1 from level 14. 17th write dropped; with ERR_EN, overflow_err=1. Drain 16 in order; pointers wrap with no data loss.
- At level 5, assert read_enb+write_enb for 10 cycles → level stays 5 and output order is FIFO. When full with both asserted, the write is rejected and level drops to 15.
- Mid-packet (remaining=2, level=4) assert soft_reset → next cycle empty=1, level=0, pkt_busy=0, data_out=0. A new packet then works normally.
- Empty FIFO with read_enb → rd_valid=0, pointers unchanged; underflow_err=1 only when ERR_EN is defined.
